// File: rtl/freq_meter_pkg.sv
// Shared constants and helpers for the gated BCD frequency meter.
package freq_meter_pkg;

    localparam int BCD_W = 4;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

    // A 2-cycle gate still needs one counter bit.
    function automatic int gate_cnt_w(input int cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/freq_meter_bcd_digit.sv
// One decade of the BCD edge accumulator; carry ripples to the next decade.
module bcd_digit
    import freq_meter_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [BCD_W-1:0] q,
    output logic             carry
);

    assign carry = inc & (q == BCD_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc) begin
            q <= carry ? '0 : q + 4'd1;
        end
    end

endmodule

// File: rtl/freq_meter.sv
// Gated frequency meter: counts sig_in rising edges over GATE_CYCLES clk cycles, reports packed BCD.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int GATE_CYCLES = 50_000_000,
    parameter int DIGITS      = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    sig_in,
    output logic [BCD_W*DIGITS-1:0] freq_bcd,
    output logic                    overflow,
    output logic                    valid
);

    localparam int                ACC_W     = BCD_W * DIGITS;
    localparam int                GATE_W    = gate_cnt_w(GATE_CYCLES);
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [ACC_W-1:0]  ALL_NINES = {DIGITS{BCD_MAX}};

    logic              s1, s2, s3;
    logic              edge_det;
    logic [GATE_W-1:0] gate_cnt;
    logic              latch;
    logic [DIGITS-1:0] inc;
    logic [DIGITS-1:0] carry;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  acc_nxt;
    logic              ovf_acc;
    logic              ovf_evt;
    logic              ovf_nxt;

    function automatic logic [ACC_W-1:0] bcd_inc(input logic [ACC_W-1:0] v);
        logic [ACC_W-1:0] r;
        logic             c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (c) begin
                if (v[i*BCD_W +: BCD_W] == BCD_MAX) begin
                    r[i*BCD_W +: BCD_W] = '0;
                end else begin
                    r[i*BCD_W +: BCD_W] = v[i*BCD_W +: BCD_W] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [ACC_W-1:0] saturate(input logic [ACC_W-1:0] v, input logic ovf);
        return ovf ? ALL_NINES : v;
    endfunction

    // Stage: three-flop synchronizer and rising-edge detect
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= sig_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign edge_det = s2 & ~s3;

    // Stage: gate window timing
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gate_cnt <= '0;
        end else if (latch) begin
            gate_cnt <= '0;
        end else begin
            gate_cnt <= gate_cnt + 1'b1;
        end
    end

    assign latch = (gate_cnt == GATE_LAST);

    // Stage: BCD accumulator; once saturated the digits stop counting and the output is forced to all-9s
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        if (i == 0) begin : g_lsd
            assign inc[i] = edge_det & ~ovf_acc;
        end else begin : g_upper
            assign inc[i] = carry[i-1];
        end

        bcd_digit u_digit (
            .clk   (clk),
            .reset (reset),
            .clr   (latch),
            .inc   (inc[i]),
            .q     (acc[i*BCD_W +: BCD_W]),
            .carry (carry[i])
        );
    end

    assign ovf_evt = carry[DIGITS-1];
    assign ovf_nxt = ovf_acc | ovf_evt;
    assign acc_nxt = inc[0] ? bcd_inc(acc) : acc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_acc <= 1'b0;
        end else if (latch) begin
            ovf_acc <= 1'b0;
        end else if (ovf_evt) begin
            ovf_acc <= 1'b1;
        end
    end

    // Stage: result registers, loaded on the latch cycle including that cycle's edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            freq_bcd <= '0;
            overflow <= 1'b0;
            valid    <= 1'b0;
        end else begin
            valid <= latch;
            if (latch) begin
                freq_bcd <= saturate(acc_nxt, ovf_nxt);
                overflow <= ovf_nxt;
            end
        end
    end

endmodule

// File: tb/tb_freq_meter.sv
// Scoreboard bench for freq_meter: two instances (2 digits and 1 digit) share one stimulus.
module tb_freq_meter;

    localparam int G = 100;

    logic       clk    = 1'b0;
    logic       reset  = 1'b1;
    logic       sig_in = 1'b0;
    logic [7:0] f2;
    logic       o2, v2;
    logic [3:0] f1;
    logic       o1, v1;

    int checks = 0;
    int fails  = 0;

    // Reference model state: posedge index since reset release, pending counted-edge times, window results
    int n         = 0;
    bit prev      = 1'b0;
    bit exp_valid = 1'b0;
    int pend[$];
    int expq[$];

    always #5 clk = ~clk;

    freq_meter #(.GATE_CYCLES(G), .DIGITS(2)) u_d2 (
        .clk(clk), .reset(reset), .sig_in(sig_in),
        .freq_bcd(f2), .overflow(o2), .valid(v2)
    );

    freq_meter #(.GATE_CYCLES(G), .DIGITS(1)) u_d1 (
        .clk(clk), .reset(reset), .sig_in(sig_in),
        .freq_bcd(f1), .overflow(o1), .valid(v1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, n);
        end
    endtask

    // Decimal count -> saturated packed BCD of d digits
    function automatic logic [7:0] exp_bcd(input int cnt, input int d, output bit ovf);
        int         maxv = 1;
        int         v;
        logic [7:0] r = '0;
        for (int i = 0; i < d; i++) maxv *= 10;
        maxv -= 1;
        ovf = (cnt > maxv);
        v = ovf ? maxv : cnt;
        for (int i = 0; i < d; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v /= 10;
        end
        return r;
    endfunction

    // A rise sampled at posedge k is counted at k+2; windows close at every multiple of G
    task automatic model_step();
        int c;
        if (reset) begin
            n = 0;
            prev = 1'b0;
            pend.delete();
            exp_valid = 1'b0;
        end else begin
            n++;
            if (sig_in && !prev) pend.push_back(n + 2);
            prev = sig_in;
            exp_valid = (n % G == 0);
            if (exp_valid) begin
                c = 0;
                while (pend.size() > 0 && pend[0] <= n) begin
                    void'(pend.pop_front());
                    c++;
                end
                expq.push_back(c);
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Monitor
    initial forever begin
        int         c;
        bit         eo2, eo1;
        logic [7:0] e2, e1;
        @(negedge clk);
        chk("valid_d2", 32'(v2), 32'(exp_valid));
        chk("valid_d1", 32'(v1), 32'(exp_valid));
        if (v2 === 1'b1) begin
            if (expq.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL sb_empty: got valid, expected no result (cycle %0d)", n);
            end else begin
                c  = expq.pop_front();
                e2 = exp_bcd(c, 2, eo2);
                e1 = exp_bcd(c, 1, eo1);
                chk("sb_freq_d2", 32'(f2), 32'(e2));
                chk("sb_ovf_d2", 32'(o2), 32'(eo2));
                chk("sb_freq_d1", 32'(f1), 32'(e1[3:0]));
                chk("sb_ovf_d1", 32'(o1), 32'(eo1));
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish, expected finish by 300000");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_valid(input string name);
        for (int i = 0; i < 2*G; i++) begin
            tick();
            if (v2) break;
        end
        chk(name, 32'(v2), 32'd1);
    endtask

    task automatic run_pattern(input int hi, input int lo, input logic [7:0] e2,
                               input logic [3:0] e1, input bit eo1, input string name);
        int seen = 0;
        int ph   = 0;
        for (int i = 0; i < 5*G && seen < 4; i++) begin
            tick();
            if (v2) begin
                seen++;
                if (seen >= 3) begin
                    chk({name, "_f2"}, 32'(f2), 32'(e2));
                    chk({name, "_o2"}, 32'(o2), 32'd0);
                    chk({name, "_f1"}, 32'(f1), 32'(e1));
                    chk({name, "_o1"}, 32'(o1), 32'(eo1));
                end
            end
            sig_in = (ph < hi);
            ph = (ph + 1) % (hi + lo);
        end
        chk({name, "_windows"}, 32'(seen), 32'd4);
    endtask

    task automatic align(input int off, input bit toggle, input string name);
        for (int i = 0; i < 2*G && (n % G) != off; i++) begin
            tick();
            if (toggle && (i % 3 == 0)) sig_in = ~sig_in;
        end
        chk(name, 32'(n % G), 32'(off));
    endtask

    task automatic boundary(input int off, input logic [7:0] first, input logic [7:0] second,
                            input string name);
        int seen = 0;
        sig_in = 1'b0;
        repeat (G) tick();
        align(off, 1'b0, {name, "_align"});
        sig_in = 1'b1;
        for (int i = 0; i < 3*G && seen < 2; i++) begin
            tick();
            if (i == 3) sig_in = 1'b0;
            if (v2) begin
                seen++;
                chk({name, "_f2"}, 32'(f2), 32'(seen == 1 ? first : second));
            end
        end
        chk({name, "_windows"}, 32'(seen), 32'd2);
    endtask

    initial begin
        int lat;
        repeat (3) tick();
        chk("rst_freq_d2", 32'(f2), 32'd0);
        chk("rst_ovf_d2", 32'(o2), 32'd0);
        chk("rst_valid_d2", 32'(v2), 32'd0);
        chk("rst_freq_d1", 32'(f1), 32'd0);
        reset = 1'b0;

        for (int w = 1; w <= 3; w++) begin
            wait_valid("idle_valid");
            chk("idle_cycle", 32'(n), 32'(w * G));
            chk("idle_freq_d2", 32'(f2), 32'd0);
            chk("idle_ovf_d2", 32'(o2), 32'd0);
        end

        run_pattern(5, 5, 8'h10, 4'h9, 1'b1, "steady");
        run_pattern(2, 2, 8'h25, 4'h9, 1'b1, "ovf");

        boundary(97, 8'h01, 8'h00, "bnd_in");
        boundary(98, 8'h00, 8'h01, "bnd_next");

        for (int seg = 0; seg < 60; seg++) begin
            sig_in = ~sig_in;
            repeat ($urandom_range(2, 9)) tick();
        end

        // Reset in the middle of a busy window, released with sig_in held high
        align(50, 1'b1, "mid_align");
        reset  = 1'b1;
        sig_in = 1'b1;
        #1;
        chk("mid_rst_freq_d2", 32'(f2), 32'd0);
        chk("mid_rst_ovf_d2", 32'(o2), 32'd0);
        chk("mid_rst_valid_d2", 32'(v2), 32'd0);
        chk("mid_rst_freq_d1", 32'(f1), 32'd0);
        chk("mid_rst_ovf_d1", 32'(o1), 32'd0);
        chk("mid_rst_valid_d1", 32'(v1), 32'd0);
        repeat (3) tick();
        reset = 1'b0;
        lat = 0;
        for (int c = 1; c <= G + 5; c++) begin
            tick();
            if (v2) begin
                lat = c;
                break;
            end
        end
        chk("mid_first_latency", 32'(lat), 32'(G));
        chk("mid_high_release_f2", 32'(f2), 32'h01);

        sig_in = 1'b0;
        repeat (G + 10) tick();
        chk("sb_drained", 32'(expq.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
